// File: rtl/arm7tdmi_ice_pkg.sv
// ============================================================================
// Package : arm7tdmi_ice_pkg
// Desc    : Shared constants, address map and watchpoint config type for chain 2.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package arm7tdmi_ice_pkg;

    localparam int          ICE_CHAIN_LEN = 38;
    localparam logic [3:0]  DCC_VERSION   = 4'h1;

    localparam logic [4:0] ICE_ADDR_DBG_CTRL       = 5'h00;
    localparam logic [4:0] ICE_ADDR_DBG_STATUS     = 5'h01;
    localparam logic [4:0] ICE_ADDR_DCC_CTRL       = 5'h04;
    localparam logic [4:0] ICE_ADDR_DCC_DATA       = 5'h05;
    localparam logic [4:0] ICE_ADDR_WP0_ADDR_VAL   = 5'h08;
    localparam logic [4:0] ICE_ADDR_WP0_ADDR_MASK  = 5'h09;
    localparam logic [4:0] ICE_ADDR_WP0_DATA_VAL   = 5'h0A;
    localparam logic [4:0] ICE_ADDR_WP0_DATA_MASK  = 5'h0B;
    localparam logic [4:0] ICE_ADDR_WP0_CTRL_VAL   = 5'h0C;
    localparam logic [4:0] ICE_ADDR_WP0_CTRL_MASK  = 5'h0D;
    localparam logic [4:0] ICE_ADDR_WP1_ADDR_VAL   = 5'h10;
    localparam logic [4:0] ICE_ADDR_WP1_ADDR_MASK  = 5'h11;
    localparam logic [4:0] ICE_ADDR_WP1_DATA_VAL   = 5'h12;
    localparam logic [4:0] ICE_ADDR_WP1_DATA_MASK  = 5'h13;
    localparam logic [4:0] ICE_ADDR_WP1_CTRL_VAL   = 5'h14;
    localparam logic [4:0] ICE_ADDR_WP1_CTRL_MASK  = 5'h15;

    typedef struct packed {
        logic [7:0]  ctrl_mask;
        logic [8:0]  ctrl_val;
        logic [31:0] data_mask;
        logic [31:0] data_val;
        logic [31:0] addr_mask;
        logic [31:0] addr_val;
    } wp_cfg_t;

    // sel is the low 3 address bits within a watchpoint block; 6 and 7 are holes.
    function automatic logic [31:0] wp_read(input wp_cfg_t c, input logic [2:0] sel);
        logic [31:0] r;
        r = 32'h0;
        case (sel)
            3'd0:    r = c.addr_val;
            3'd1:    r = c.addr_mask;
            3'd2:    r = c.data_val;
            3'd3:    r = c.data_mask;
            3'd4:    r = {23'h0, c.ctrl_val};
            3'd5:    r = {24'h0, c.ctrl_mask};
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    function automatic wp_cfg_t wp_write(input wp_cfg_t c, input logic [2:0] sel,
                                         input logic [31:0] d);
        wp_cfg_t r;
        r = c;
        case (sel)
            3'd0:    r.addr_val  = d;
            3'd1:    r.addr_mask = d;
            3'd2:    r.data_val  = d;
            3'd3:    r.data_mask = d;
            3'd4:    r.ctrl_val  = d[8:0];
            3'd5:    r.ctrl_mask = d[7:0];
            default: r = c;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/arm7tdmi_ice_chain2_if.sv
// ============================================================================
// Interface : arm7tdmi_ice_chain2_if
// Desc      : Core-side debug comms channel handshake bundle.
// Rev       : 1.0
// ============================================================================
`default_nettype none

interface arm7tdmi_ice_chain2_if;
    logic        core_dcc_wr_valid;
    logic [31:0] core_dcc_wdata;
    logic        core_dcc_wr_ready;
    logic        core_dcc_rd_valid;
    logic [31:0] core_dcc_rdata;
    logic        core_dcc_rd;

    modport master (
        output core_dcc_wr_valid, core_dcc_wdata, core_dcc_rd,
        input  core_dcc_wr_ready, core_dcc_rd_valid, core_dcc_rdata
    );

    modport slave (
        input  core_dcc_wr_valid, core_dcc_wdata, core_dcc_rd,
        output core_dcc_wr_ready, core_dcc_rd_valid, core_dcc_rdata
    );
endinterface

`default_nettype wire

// File: rtl/arm7tdmi_ice_dcc.sv
// ============================================================================
// Module : arm7tdmi_ice_dcc
// Desc   : Debug comms channel flags and data registers for both directions.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module arm7tdmi_ice_dcc (
    input  wire logic        tck,
    input  wire logic        trst_n,
    input  wire logic        i_host_wr,
    input  wire logic [31:0] i_host_wdata,
    input  wire logic        i_host_rd,
    arm7tdmi_ice_chain2_if.slave dcc,
    output logic             o_r_flag,
    output logic             o_w_flag,
    output logic [31:0]      o_c2h
);
    logic        r_r;
    logic        r_w;
    logic [31:0] r_h2c;
    logic [31:0] r_c2h;
    logic        w_core_wr;

    assign w_core_wr = dcc.core_dcc_wr_valid & ~r_w;

    // A host write beats a same-edge core read; a core write beats a same-edge capture clear.
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            r_r   <= 1'b0;
            r_w   <= 1'b0;
            r_h2c <= 32'h0;
            r_c2h <= 32'h0;
        end else begin
            if (i_host_wr) begin
                r_r   <= 1'b1;
                r_h2c <= i_host_wdata;
            end else if (dcc.core_dcc_rd) begin
                r_r   <= 1'b0;
            end

            if (w_core_wr) begin
                r_w   <= 1'b1;
                r_c2h <= dcc.core_dcc_wdata;
            end else if (i_host_rd) begin
                r_w   <= 1'b0;
            end
        end
    end

    assign dcc.core_dcc_wr_ready = ~r_w;
    assign dcc.core_dcc_rd_valid = r_r;
    assign dcc.core_dcc_rdata    = r_h2c;
    assign o_r_flag              = r_r;
    assign o_w_flag              = r_w;
    assign o_c2h                 = r_c2h;

endmodule

`default_nettype wire

// File: rtl/arm7tdmi_ice_chain2.sv
// ============================================================================
// Module : arm7tdmi_ice_chain2
// Desc   : EmbeddedICE scan chain 2: 38-bit DR with addressed register file.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module arm7tdmi_ice_chain2 #(
    parameter int         CHAIN_LEN   = arm7tdmi_ice_pkg::ICE_CHAIN_LEN,
    parameter logic [3:0] DCC_VERSION = arm7tdmi_ice_pkg::DCC_VERSION
) (
    input  wire logic         tck,
    input  wire logic         trst_n,
    input  wire logic         tdi,
    input  wire logic         ice_select,
    input  wire logic         capture_dr,
    input  wire logic         shift_dr,
    input  wire logic         update_dr,
    output logic              ice_tdo,
    input  wire logic [4:0]   dbg_status_in,
    output logic              dbgrq_o,
    output logic              dbgack_force_o,
    output logic              intdis_o,
    arm7tdmi_ice_chain2_if.slave dcc,
    output logic [144:0]      wp0_cfg_o,
    output logic [144:0]      wp1_cfg_o
);
    import arm7tdmi_ice_pkg::*;

    logic [CHAIN_LEN-1:0] r_sr;
    logic [4:0]           r_rd_addr;
    logic [2:0]           r_dbg_ctrl;
    wp_cfg_t              r_wp0;
    wp_cfg_t              r_wp1;

    logic        w_cap;
    logic        w_shift;
    logic        w_upd;
    logic        w_upd_wr;
    logic [4:0]  w_upd_addr;
    logic [31:0] w_upd_data;
    logic [31:0] w_rd_data;
    logic        w_r_flag;
    logic        w_w_flag;
    logic [31:0] w_c2h;

    assign w_cap      = ice_select & capture_dr;
    assign w_shift    = ice_select & shift_dr;
    assign w_upd      = ice_select & update_dr;
    assign w_upd_wr   = r_sr[CHAIN_LEN-1];
    assign w_upd_addr = r_sr[CHAIN_LEN-2 -: 5];
    assign w_upd_data = r_sr[31:0];

    arm7tdmi_ice_dcc u_dcc (
        .tck          (tck),
        .trst_n       (trst_n),
        .i_host_wr    (w_upd & w_upd_wr & (w_upd_addr == ICE_ADDR_DCC_DATA)),
        .i_host_wdata (w_upd_data),
        .i_host_rd    (w_cap & (r_rd_addr == ICE_ADDR_DCC_DATA)),
        .dcc          (dcc),
        .o_r_flag     (w_r_flag),
        .o_w_flag     (w_w_flag),
        .o_c2h        (w_c2h)
    );

    always_comb begin
        w_rd_data = 32'h0;
        case (r_rd_addr)
            ICE_ADDR_DBG_CTRL:   w_rd_data = {29'h0, r_dbg_ctrl};
            ICE_ADDR_DBG_STATUS: w_rd_data = {27'h0, dbg_status_in};
            ICE_ADDR_DCC_CTRL:   w_rd_data = {DCC_VERSION, 26'h0, w_w_flag, w_r_flag};
            ICE_ADDR_DCC_DATA:   w_rd_data = w_c2h;
            default: begin
                if (r_rd_addr[4:3] == 2'b01)
                    w_rd_data = wp_read(r_wp0, r_rd_addr[2:0]);
                else if (r_rd_addr[4:3] == 2'b10)
                    w_rd_data = wp_read(r_wp1, r_rd_addr[2:0]);
            end
        endcase
    end

    // Update with R/W=0 only retargets the next capture; the data field is discarded.
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            r_sr       <= '0;
            r_rd_addr  <= 5'h0;
            r_dbg_ctrl <= 3'h0;
            r_wp0      <= '0;
            r_wp1      <= '0;
        end else begin
            if (w_cap)
                r_sr <= {{(CHAIN_LEN-32){1'b0}}, w_rd_data};
            else if (w_shift)
                r_sr <= {tdi, r_sr[CHAIN_LEN-1:1]};

            if (w_upd) begin
                if (w_upd_wr) begin
                    if (w_upd_addr == ICE_ADDR_DBG_CTRL)
                        r_dbg_ctrl <= w_upd_data[2:0];
                    if (w_upd_addr[4:3] == 2'b01)
                        r_wp0 <= wp_write(r_wp0, w_upd_addr[2:0], w_upd_data);
                    if (w_upd_addr[4:3] == 2'b10)
                        r_wp1 <= wp_write(r_wp1, w_upd_addr[2:0], w_upd_data);
                end else begin
                    r_rd_addr <= w_upd_addr;
                end
            end
        end
    end

    assign ice_tdo        = r_sr[0];
    assign dbgack_force_o = r_dbg_ctrl[0];
    assign dbgrq_o        = r_dbg_ctrl[1];
    assign intdis_o       = r_dbg_ctrl[2];
    assign wp0_cfg_o      = r_wp0;
    assign wp1_cfg_o      = r_wp1;

endmodule

`default_nettype wire

// File: tb/tb_arm7tdmi_ice_chain2.sv
// ============================================================================
// Module : tb_arm7tdmi_ice_chain2
// Desc   : Self-checking bench for scan chain 2 register file and DCC.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_arm7tdmi_ice_chain2;
    import arm7tdmi_ice_pkg::*;

    logic         tck = 1'b0;
    logic         trst_n = 1'b0;
    logic         tdi = 1'b0;
    logic         ice_select = 1'b1;
    logic         capture_dr = 1'b0;
    logic         shift_dr = 1'b0;
    logic         update_dr = 1'b0;
    logic [4:0]   dbg_status_in = 5'h0;
    logic         ice_tdo;
    logic         dbgrq_o;
    logic         dbgack_force_o;
    logic         intdis_o;
    logic [144:0] wp0_cfg_o;
    logic [144:0] wp1_cfg_o;

    arm7tdmi_ice_chain2_if dcc_if ();

    arm7tdmi_ice_chain2 dut (
        .tck            (tck),
        .trst_n         (trst_n),
        .tdi            (tdi),
        .ice_select     (ice_select),
        .capture_dr     (capture_dr),
        .shift_dr       (shift_dr),
        .update_dr      (update_dr),
        .ice_tdo        (ice_tdo),
        .dbg_status_in  (dbg_status_in),
        .dbgrq_o        (dbgrq_o),
        .dbgack_force_o (dbgack_force_o),
        .intdis_o       (intdis_o),
        .dcc            (dcc_if),
        .wp0_cfg_o      (wp0_cfg_o),
        .wp1_cfg_o      (wp1_cfg_o)
    );

    always #5 tck = ~tck;

    typedef struct {
        logic        chk;
        logic [31:0] val;
        string       name;
    } exp_t;

    typedef struct {
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
        string       name;
    } vec_t;

    exp_t exp_q[$];
    vec_t tbl[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, req);
        end
    endtask

    task automatic scan(input logic wr, input logic [4:0] a, input logic [31:0] d,
                        input logic cw_en, input logic [31:0] cw_d, input logic crd_en,
                        output logic [37:0] cap);
        logic [37:0] v;
        v = {wr, a, d};
        @(negedge tck);
        capture_dr = 1'b1;
        if (cw_en) begin
            dcc_if.core_dcc_wr_valid = 1'b1;
            dcc_if.core_dcc_wdata    = cw_d;
        end
        @(negedge tck);
        capture_dr = 1'b0;
        dcc_if.core_dcc_wr_valid = 1'b0;
        shift_dr = 1'b1;
        for (int i = 0; i < 38; i++) begin
            cap[i] = ice_tdo;
            tdi    = v[i];
            @(negedge tck);
        end
        shift_dr  = 1'b0;
        update_dr = 1'b1;
        if (crd_en) dcc_if.core_dcc_rd = 1'b1;
        @(negedge tck);
        update_dr = 1'b0;
        dcc_if.core_dcc_rd = 1'b0;
    endtask

    // Each scan checks the capture queued by the previous scan and queues its own.
    task automatic do_scan(input logic wr, input logic [4:0] a, input logic [31:0] d,
                           input logic [31:0] exp, input string nm,
                           input logic cw_en = 1'b0, input logic [31:0] cw_d = 32'h0,
                           input logic crd_en = 1'b0);
        logic [37:0] cap;
        exp_t        e;
        scan(wr, a, d, cw_en, cw_d, crd_en, cap);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.chk) check({"capture ", e.name}, {26'h0, cap}, {32'h0, 6'h0, e.val});
        end
        exp_q.push_back('{!wr, exp, nm});
    endtask

    task automatic core_write(input logic [31:0] d);
        @(negedge tck);
        dcc_if.core_dcc_wr_valid = 1'b1;
        dcc_if.core_dcc_wdata    = d;
        @(negedge tck);
        dcc_if.core_dcc_wr_valid = 1'b0;
    endtask

    task automatic core_read();
        @(negedge tck);
        dcc_if.core_dcc_rd = 1'b1;
        @(negedge tck);
        dcc_if.core_dcc_rd = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        wp_cfg_t     c0;
        wp_cfg_t     c1;
        logic [37:0] cap;
        logic [37:0] v;
        logic        tdo_before;

        dcc_if.core_dcc_wr_valid = 1'b0;
        dcc_if.core_dcc_wdata    = 32'h0;
        dcc_if.core_dcc_rd       = 1'b0;
        dbg_status_in            = 5'b10101;

        tbl.push_back('{1'b0, 5'h01, 32'h0,        32'h0000_0015, "rd_status"});
        tbl.push_back('{1'b1, 5'h08, 32'h12345678, 32'h0,         "wr_wp0_av"});
        tbl.push_back('{1'b0, 5'h08, 32'h0,        32'h12345678,  "rd_wp0_av"});
        tbl.push_back('{1'b1, 5'h09, 32'hFFFF0000, 32'h0,         "wr_wp0_am"});
        tbl.push_back('{1'b1, 5'h0C, 32'hFFFFFFFF, 32'h0,         "wr_wp0_cv"});
        tbl.push_back('{1'b0, 5'h0C, 32'h0,        32'h0000_01FF, "rd_wp0_cv"});
        tbl.push_back('{1'b1, 5'h0D, 32'hFFFFFFFF, 32'h0,         "wr_wp0_cm"});
        tbl.push_back('{1'b0, 5'h0D, 32'h0,        32'h0000_00FF, "rd_wp0_cm"});
        tbl.push_back('{1'b1, 5'h12, 32'hDEADBEEF, 32'h0,         "wr_wp1_dv"});
        tbl.push_back('{1'b0, 5'h12, 32'h0,        32'hDEADBEEF,  "rd_wp1_dv"});
        tbl.push_back('{1'b1, 5'h1F, 32'h00000055, 32'h0,         "wr_unmapped"});
        tbl.push_back('{1'b0, 5'h1F, 32'h0,        32'h0,         "rd_unmapped"});
        tbl.push_back('{1'b1, 5'h01, 32'hFFFFFFFF, 32'h0,         "wr_status_ro"});
        tbl.push_back('{1'b0, 5'h01, 32'h0,        32'h0000_0015, "rd_status2"});
        tbl.push_back('{1'b1, 5'h00, 32'hFFFFFFFF, 32'h0,         "wr_ctrl"});
        tbl.push_back('{1'b0, 5'h00, 32'h0,        32'h0000_0007, "rd_ctrl"});
        tbl.push_back('{1'b0, 5'h09, 32'h0,        32'hFFFF0000,  "rd_wp0_am"});
        tbl.push_back('{1'b1, 5'h00, 32'h00000002, 32'h0,         "wr_ctrl2"});
        tbl.push_back('{1'b0, 5'h04, 32'h0,        32'h1000_0000, "rd_dcc_idle"});

        repeat (3) @(negedge tck);
        check("reset dbgrq_o", {63'h0, dbgrq_o}, 64'h0);
        check("reset wr_ready", {63'h0, dcc_if.core_dcc_wr_ready}, 64'h1);
        check("reset rd_valid", {63'h0, dcc_if.core_dcc_rd_valid}, 64'h0);
        check("reset ice_tdo", {63'h0, ice_tdo}, 64'h0);
        check("reset wp0_cfg", {32'h0, wp0_cfg_o[31:0]}, 64'h0);
        trst_n = 1'b1;
        exp_q.push_back('{1'b1, 32'h0, "reset_ctrl"});

        for (int i = 0; i < tbl.size(); i++) begin
            do_scan(tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].exp, tbl[i].name);
            if (tbl[i].wr && tbl[i].addr == 5'h08)
                check("wp0 addr_val after update", {32'h0, wp0_cfg_o[31:0]}, {32'h0, tbl[i].data});
        end

        c0 = wp0_cfg_o;
        c1 = wp1_cfg_o;
        check("wp0 addr_mask", {32'h0, c0.addr_mask}, 64'hFFFF0000);
        check("wp0 ctrl_val", {55'h0, c0.ctrl_val}, 64'h1FF);
        check("wp0 ctrl_mask", {56'h0, c0.ctrl_mask}, 64'hFF);
        check("wp1 data_val", {32'h0, c1.data_val}, 64'hDEADBEEF);
        check("wp1 addr_val", {32'h0, c1.addr_val}, 64'h0);
        check("ctrl outputs", {61'h0, intdis_o, dbgrq_o, dbgack_force_o}, 64'h2);

        // Core-to-host direction.
        do_scan(1'b0, 5'h04, 32'h0, 32'h1000_0002, "dcc_ctrl_w");
        core_write(32'hCAFEF00D);
        check("wr_ready after core write", {63'h0, dcc_if.core_dcc_wr_ready}, 64'h0);
        core_write(32'h11111111);
        do_scan(1'b0, 5'h05, 32'h0, 32'hCAFEF00D, "c2h_data");
        do_scan(1'b0, 5'h04, 32'h0, 32'h1000_0000, "dcc_ctrl_clr");
        check("wr_ready after c2h read", {63'h0, dcc_if.core_dcc_wr_ready}, 64'h1);
        do_scan(1'b0, 5'h05, 32'h0, 32'hCAFEF00D, "c2h_stale");
        do_scan(1'b0, 5'h04, 32'h0, 32'h1000_0002, "dcc_ctrl_race", 1'b1, 32'hBEEF0001);
        check("wr_ready after capture race", {63'h0, dcc_if.core_dcc_wr_ready}, 64'h0);

        // Host-to-core direction.
        do_scan(1'b1, 5'h05, 32'hA5A5A5A5, 32'h0, "h2c_wr");
        check("rd_valid after host write", {63'h0, dcc_if.core_dcc_rd_valid}, 64'h1);
        check("rdata after host write", {32'h0, dcc_if.core_dcc_rdata}, 64'hA5A5A5A5);
        do_scan(1'b0, 5'h04, 32'h0, 32'h1000_0003, "dcc_ctrl_rw");
        do_scan(1'b0, 5'h05, 32'h0, 32'hBEEF0001, "c2h_race");
        core_read();
        check("rd_valid after core read", {63'h0, dcc_if.core_dcc_rd_valid}, 64'h0);
        do_scan(1'b1, 5'h05, 32'h5A5A5A5A, 32'h0, "h2c_wr2");
        do_scan(1'b1, 5'h05, 32'h0F0F0F0F, 32'h0, "h2c_race", 1'b0, 32'h0, 1'b1);
        check("rd_valid write beats read", {63'h0, dcc_if.core_dcc_rd_valid}, 64'h1);
        check("rdata write beats read", {32'h0, dcc_if.core_dcc_rdata}, 64'h0F0F0F0F);

        // Deselected scan must leave everything untouched.
        do_scan(1'b0, 5'h0D, 32'h0, 32'h0000_00FF, "wp0_cm_held");
        tdo_before = ice_tdo;
        ice_select = 1'b0;
        scan(1'b1, 5'h00, 32'h5, 1'b0, 32'h0, 1'b0, cap);
        ice_select = 1'b1;
        check("deselected tdo", {26'h0, cap}, {26'h0, {38{tdo_before}}});
        check("deselected ctrl", {61'h0, intdis_o, dbgrq_o, dbgack_force_o}, 64'h2);
        do_scan(1'b0, 5'h00, 32'h0, 32'h0000_0002, "ctrl_held");
        do_scan(1'b0, 5'h00, 32'h0, 32'h0000_0002, "ctrl_held2");

        // Reset in the middle of a write scan.
        v = {1'b1, 5'h00, 32'h5};
        @(negedge tck);
        capture_dr = 1'b1;
        @(negedge tck);
        capture_dr = 1'b0;
        shift_dr   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tdi = v[i];
            @(negedge tck);
        end
        shift_dr = 1'b0;
        trst_n   = 1'b0;
        @(negedge tck);
        check("mid-shift reset dbgrq_o", {63'h0, dbgrq_o}, 64'h0);
        check("mid-shift reset ice_tdo", {63'h0, ice_tdo}, 64'h0);
        check("mid-shift reset wr_ready", {63'h0, dcc_if.core_dcc_wr_ready}, 64'h1);
        check("mid-shift reset rd_valid", {63'h0, dcc_if.core_dcc_rd_valid}, 64'h0);
        trst_n = 1'b1;
        @(negedge tck);
        update_dr = 1'b1;
        @(negedge tck);
        update_dr = 1'b0;
        check("post-reset update ctrl", {61'h0, intdis_o, dbgrq_o, dbgack_force_o}, 64'h0);
        exp_q.delete();
        exp_q.push_back('{1'b1, 32'h0, "post_reset_ctrl"});
        do_scan(1'b0, 5'h08, 32'h0, 32'h0, "wp0_av_reset");
        do_scan(1'b0, 5'h00, 32'h0, 32'h0, "ctrl_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/arm7tdmi_ice_chain2.md
# arm7tdmi_ice_chain2

EmbeddedICE scan chain 2 for the ARM7TDMI debug logic: a 38-bit JTAG data register consuming the TAP controller's DR-state strobes and `ice_select`, and returning serial data on `ice_tdo`. It implements the addressed EmbeddedICE register file: debug control/status, the debug comms channel (DCC) and two watchpoint units. Register contents feed the core's debug request path and the watchpoint comparators.

## Interface
- `CHAIN_LEN`, 38: scan chain length. Layout: [31:0] data, [36:32] address, [37] R/W (1 = write).
- `DCC_VERSION`, 4'h1: value returned in DCC control [31:28].
- `tck` in 1: JTAG clock, the only clock; all flops on rising edge.
- `trst_n` in 1: asynchronous, active-low reset.
- `tdi` in 1: serial in.
- `ice_select`, `capture_dr`, `shift_dr`, `update_dr` in 1 each: TAP state decodes; every action is qualified by `ice_select`.
- `ice_tdo` out 1: serial out, combinational `sr[0]`.
- `dbg_status_in` in 5: {TBIT, nMREQ, IFEN, DBGRQ, DBGACK} from core.
- `dbgrq_o`, `dbgack_force_o`, `intdis_o` out 1 each: debug control bits [1], [0], [2].
- `core_dcc_wr_valid` in 1, `core_dcc_wdata` in 32, `core_dcc_wr_ready` out 1: core-to-host DCC write.
- `core_dcc_rd_valid` out 1, `core_dcc_rdata` out 32, `core_dcc_rd` in 1: host-to-core DCC read.
- `wp0_cfg_o`, `wp1_cfg_o` out 145 each: {ctrl_mask[7:0], ctrl_val[8:0], data_mask, data_val, addr_mask, addr_val}.

## Operation
- Address map: 0x00 debug control (3 bits, R/W); 0x01 debug status (5 bits, RO, live `dbg_status_in`); 0x04 DCC control (RO: [0] R, [1] W, [31:28] version); 0x05 DCC data; 0x08–0x0D WP0 addr_val, addr_mask, data_val, data_mask, ctrl_val, ctrl_mask; 0x10–0x15 WP1 same order.
- Capture-DR (`ice_select & capture_dr`): `sr[31:0]` ← read value at `rd_addr`; `sr[37:32]` ← 0. Read at 0x05 returns core-to-host register and clears W.
- Shift-DR: `sr` ← {`tdi`, `sr[37:1]`}, LSB out first.
- Update-DR: if `sr[37]`=1 write `sr[31:0]` (truncated to register width) to `sr[36:32]`; if 0, `rd_addr` ← `sr[36:32]` and no write.
- Unmapped or RO addresses: writes ignored, reads return 0 (status/DCC ctrl return defined value).
- DCC host→core: host write to 0x05 loads `h2c`, sets R (overwrites if R already 1). `core_dcc_rd_valid`=R; `core_dcc_rd` with R=1 clears R. Host write and `core_dcc_rd` same edge: write wins, R=1.
- DCC core→host: `core_dcc_wr_ready` = ~W; write with ready loads `c2h`, sets W; write with W=1 ignored. Capture of 0x05 and core write same edge: capture returns old `c2h`, W ends 1.
- Reset: `sr`, `rd_addr`, all registers, R, W = 0; all outputs 0 except `core_dcc_wr_ready`=1, `ice_tdo`=0. Reset mid-shift discards shift contents.

## Timing
- Register write visible on outputs one `tck` after the Update-DR edge.
- Read: address latched in scan N; data returned during scan N+1 (first bit on `ice_tdo` after Capture-DR edge).
- DCC flags update on the same edge as the causing event; flag outputs are registered.
- `ice_select` low: `sr`, `rd_addr` and host-side registers hold; core-side DCC handshake still operates.

## Structure
- Package `arm7tdmi_ice_pkg`: `ICE_CHAIN_LEN`, address constants (`ICE_ADDR_DBG_CTRL` … `ICE_ADDR_WP1_CTRL_MASK`), `wp_cfg_t` packed struct, `DCC_VERSION`.
- Sub-module `arm7tdmi_ice_dcc`: R/W flags, `h2c`/`c2h` registers, both handshakes, priority rules.

## Test plan
- Reset, scan read 0x01 with `dbg_status_in`=5'b10101 -> second scan returns 0x00000015; `dbgrq_o`=0, `core_dcc_wr_ready`=1.
- Write 0x08 = 0x12345678, then read 0x08 -> returns 0x12345678; `wp0_cfg_o` addr_val=0x12345678 one tck after Update-DR.
- Core writes 0xCAFEF00D -> DCC ctrl reads 0x10000002; read 0x05 returns 0xCAFEF00D; next DCC ctrl read 0x10000000; second core write while W=1 ignored.
- Host writes 0x05 = 0xA5A5A5A5 -> `core_dcc_rd_valid`=1, `core_dcc_rdata`=0xA5A5A5A5; pulse `core_dcc_rd` -> valid 0; simultaneous write+rd -> valid stays 1.
- Write to 0x1F and to 0x01 -> no register change; read 0x1F returns 0; scan with `ice_select`=0 -> `ice_tdo` and registers unchanged.
- Assert `trst_n` after 20 shift bits of a write to 0x00 -> no write, `dbgrq_o`=0, `sr`=0.
